cdc_a2s_rx_ctrl: RTL

- Synchronous-side receive controller for the async-to-sync CDC channel.
- Synchronizes the CDC request Si, runs the four-phase Si/So handshake, and captures the 64-bit Din word into a small show-ahead FIFO.
- Presents captured words to the clocked core on a valid/ready stream and counts received tokens.
- Replaces the behavioural receive loop used in CDC bring-up benches with synthesizable RTL.

---
 rtl/cdc_a2s_rx_ctrl_if.sv | 29 ++
 rtl/cdc_a2s_rx_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/cdc_a2s_rx_ctrl_if.sv
// Bundle for the async-to-sync receive controller: CDC request/ack/data on one side,
// the valid/ready output stream and status on the other.
interface cdc_a2s_rx_ctrl_if #(
   parameter int DW    = 64,
   parameter int DEPTH = 4,
   parameter int CW    = 16
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic          Si;
   logic          So;
   logic [DW-1:0] Din;
   logic          En;
   logic [DW-1:0] Dout;
   logic          DoutV;
   logic          DoutR;
   logic [LW-1:0] Level;
   logic [CW-1:0] RxCount;

   modport slave (
      input  Si, Din, En, DoutR,
      output So, Dout, DoutV, Level, RxCount
   );

   modport master (
      output Si, Din, En, DoutR,
      input  So, Dout, DoutV, Level, RxCount
   );
endinterface

// File: rtl/cdc_a2s_rx_ctrl.sv
// Synchronous-side receiver for the async-to-sync CDC channel: synchronizes Si, runs the
// four-phase Si/So handshake and buffers captured words in a show-ahead FIFO.
//
// state | meaning
// IDLE  | So=0, waiting for synchronized Si with En and FIFO space
// ACK   | So=1, word captured, waiting for synchronized Si to fall
module cdc_a2s_rx_ctrl #(
   parameter int DW          = 64,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CW          = 16
) (
   input logic              CLK,
   input logic              RESET,
   cdc_a2s_rx_ctrl_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   si_s;
   logic [AW:0]            wr_ptr, rd_ptr;
   logic [DW-1:0]          mem [DEPTH];
   logic [DW-1:0]          hold_q;
   logic [CW-1:0]          count_q;
   logic                   full, empty, push, pop;

   assign si_s  = sync_q[SYNC_STAGES-1];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = !empty && bus.DoutR;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync_q  <= '0;
         state_q <= IDLE;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.Si};
         state_q <= state_d;
      end
   end

   // Full is judged on the current occupancy only; a pop this edge frees space for the next.
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            if (si_s && bus.En && !full) begin
               push    = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            if (!si_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         hold_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr  <= wr_ptr + 1'b1;
            count_q <= count_q + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            hold_q <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr[AW-1:0]] <= bus.Din;
   end

   // When empty, Dout shows the last word popped (zero after reset).
   assign bus.So      = (state_q == ACK);
   assign bus.DoutV   = !empty;
   assign bus.Dout    = empty ? hold_q : mem[rd_ptr[AW-1:0]];
   assign bus.Level   = wr_ptr - rd_ptr;
   assign bus.RxCount = count_q;
endmodule
